// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receive stage (start + N data LSB-first + stop) with valid/ready output.
// Optional feature macro UART_RX_PARITY_EN: an even-parity bit is expected between the data and the stop bit.
module uart_receiver #(
    parameter int UART_BITS_TRANSFERED = 8,
    parameter int CLKS_PER_BIT         = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx,
    output logic [UART_BITS_TRANSFERED-1:0] message,
    output logic                            valid,
    input  logic                            ready,
    output logic                            frame_err,
    output logic                            overrun,
    output logic                            parity_err
);
    localparam int N  = UART_BITS_TRANSFERED;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sync1;
    logic            r_rx_s;
    logic [CW-1:0]   r_clk_cnt;
    logic [BW-1:0]   r_bit_idx;
    logic [N-1:0]    r_shift;
    logic [N-1:0]    w_shift_nxt;
    logic [N-1:0]    r_message;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_cnt_clr;
    logic            w_cnt_run;
    logic            w_idx_clr;
    logic            w_bit_smp;
    logic            w_stop_smp;
    logic            w_par_bad;
    logic            w_deliver;
    logic            w_load;
    logic            w_fe;
    logic            w_ovr;
    logic            w_pe;
`ifdef UART_RX_PARITY_EN
    logic            r_parity;
    logic            r_parity_err;
    logic            w_par_smp;
`endif

    // rx is asynchronous to clk; nothing but r_rx_s is looked at downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_run   = 1'b0;
        w_idx_clr   = 1'b0;
        w_bit_smp   = 1'b0;
        w_stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_smp   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_START: begin
                if (r_clk_cnt == CNT_HALF) begin
                    w_cnt_clr   = 1'b1;
                    w_idx_clr   = 1'b1;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_run = 1'b1;
                end
            end
            S_DATA: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_bit_smp = 1'b1;
                    if (r_bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end else begin
                    w_cnt_run = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_par_smp   = 1'b1;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_run = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_stop_smp  = 1'b1;
                    w_state_nxt = r_rx_s ? S_IDLE : S_BREAK;
                end else begin
                    w_cnt_run = 1'b1;
                end
            end
            // A low stop bit parks here until the line idles, so a long break reports once
            S_BREAK: begin
                if (r_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt        = r_shift >> 1;
        w_shift_nxt[N-1]   = r_rx_s;
`ifdef UART_RX_PARITY_EN
        w_par_bad          = ^{r_shift, r_parity};
`else
        w_par_bad          = 1'b0;
`endif
        w_pe      = w_stop_smp && w_par_bad;
        w_fe      = w_stop_smp && !w_par_bad && !r_rx_s;
        w_deliver = w_stop_smp && !w_par_bad && r_rx_s;
        w_load    = w_deliver && (!r_valid || ready);
        w_ovr     = w_deliver && r_valid && !ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_cnt_clr)      r_clk_cnt <= '0;
            else if (w_cnt_run) r_clk_cnt <= r_clk_cnt + CW'(1);
            if (w_idx_clr)      r_bit_idx <= '0;
            else if (w_bit_smp) r_bit_idx <= r_bit_idx + BW'(1);
            if (w_bit_smp)      r_shift   <= w_shift_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity     <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_smp) r_parity <= r_rx_s;
            r_parity_err <= w_pe;
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // Accept and reload may coincide; valid then stays high across the handover
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_message   <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_message <= r_shift;
                r_valid   <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid   <= 1'b0;
            end
            r_frame_err <= w_fe;
            r_overrun   <= w_ovr;
        end
    end

    assign message   = r_message;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level reference model of accepted words and error pulses.
module tb_uart_receiver;
    localparam int N   = 8;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB  = N + 2 + PB;
    // posedges from the first edge that captures the start bit to the stop-bit sample
    localparam int LAT = 2 + CPB / 2 + (N + 1 + PB) * CPB;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         rx    = 1'b1;
    logic         ready = 1'b0;
    logic [N-1:0] message;
    logic         valid;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;

    int n_vec = 0;
    int n_err = 0;

    // reference model: at most one word waiting, plus the words the consumer is due to take, in order
    bit           m_pend = 1'b0;
    logic [N-1:0] m_word = '0;
    logic [N-1:0] exp_acc[$];
    int exp_fe = 0, exp_ovr = 0, exp_pe = 0;
    int act_fe = 0, act_ovr = 0, act_pe = 0;
    bit           pv = 1'b0;
    logic [N-1:0] pm = '0;

    uart_receiver #(.UART_BITS_TRANSFERED(N), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .message(message), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic line_bit(input logic [N-1:0] d, input int k, input bit stop, input bit flip);
        if (k == 0)                     return 1'b0;
        else if (k <= N)                return d[k-1];
        else if (PB != 0 && k == N + 1) return (^d) ^ flip;
        else                            return stop;
    endfunction

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rx = 1'b1;
        end
    endtask

    task automatic drain(input int n);
        tick();
        ready = 1'b1;
        if (m_pend) begin
            exp_acc.push_back(m_word);
            m_pend = 1'b0;
        end
        tick();
        chk("drain_valid_low", 32'(valid), 32'(0));
        for (int i = 0; i < n; i++) tick();
    endtask

    // mode 0: ready low; 1: ready high; 2: ready high only on the stop-sample edge
    task automatic send_frame(input logic [N-1:0] d, input bit stop, input int mode,
                              input int brk, input bit flip);
        int kind;
        kind = 0;
        for (int t = 0; t < NB * CPB; t++) begin
            tick();
            if (t == (NB * CPB) / 2) begin
                ready = (mode == 1);
                if (mode == 1 && m_pend) begin
                    exp_acc.push_back(m_word);
                    m_pend = 1'b0;
                end
            end
            if (t == LAT) begin
                chk("pre_stop_valid", 32'(valid), 32'(m_pend));
                chk("pre_stop_pulses", 32'({frame_err, overrun, parity_err}), 32'(0));
                if (mode == 2) begin
                    ready = 1'b1;
                    if (m_pend) begin
                        exp_acc.push_back(m_word);
                        m_pend = 1'b0;
                    end
                end
                if (flip) begin
                    kind = 3;
                    exp_pe++;
                end else if (!stop) begin
                    kind = 2;
                    exp_fe++;
                end else if (m_pend) begin
                    kind = 1;
                    exp_ovr++;
                end else begin
                    kind = 0;
                    m_word = d;
                    m_pend = 1'b1;
                    if (mode == 1) begin
                        exp_acc.push_back(d);
                        m_pend = 1'b0;
                    end
                end
            end
            if (t == LAT + 1) begin
                case (kind)
                    0: begin
                        chk("deliver_valid", 32'(valid), 32'(1));
                        chk("deliver_msg", 32'(message), 32'(d));
                    end
                    1: begin
                        chk("overrun_pulse", 32'(overrun), 32'(1));
                        chk("overrun_valid", 32'(valid), 32'(1));
                        chk("overrun_msg_held", 32'(message), 32'(m_word));
                    end
                    2: chk("frame_err_pulse", 32'(frame_err), 32'(1));
                    default: chk("parity_err_pulse", 32'(parity_err), 32'(1));
                endcase
                chk("pulse_count", 32'($countones({frame_err, overrun, parity_err})), 32'(kind != 0));
                if (mode == 2) ready = 1'b0;
            end
            rx = line_bit(d, t / CPB, stop, flip);
        end
        if (!stop) begin
            for (int i = 0; i < brk; i++) begin
                tick();
                rx = 1'b0;
            end
        end
    endtask

    task automatic reset_mid(input logic [N-1:0] d, input int at);
        for (int t = 0; t < at; t++) begin
            tick();
            rx = line_bit(d, t / CPB, 1'b1, 1'b0);
        end
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_msg", 32'(message), 32'(0));
        chk("rst_mid_valid", 32'(valid), 32'(0));
        chk("rst_mid_pulses", 32'({frame_err, overrun, parity_err}), 32'(0));
        m_pend = 1'b0;
        rx = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
    endtask

    // every cycle: in-order acceptance, held word stability, error-pulse tally
    initial begin : compare
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    chk("held_valid", 32'(valid), 32'(1));
                    chk("held_msg", 32'(message), 32'(pm));
                end
                if (valid && ready) begin
                    if (exp_acc.size() == 0) chk("accept_unexpected", 32'(exp_acc.size()), 32'(1));
                    else                     chk("accept_msg", 32'(message), 32'(exp_acc.pop_front()));
                end
                pv = valid && !ready;
                pm = message;
                act_fe  += int'(frame_err);
                act_ovr += int'(overrun);
                act_pe  += int'(parity_err);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [N-1:0] d;
        bit           stp;
        bit           flp;
        rst = 1'b1;
        rx = 1'b1;
        ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_msg", 32'(message), 32'(0));
        chk("reset_valid", 32'(valid), 32'(0));
        chk("reset_pulses", 32'({frame_err, overrun, parity_err}), 32'(0));
        rst = 1'b0;
        gap(5);

        send_frame(8'hA5, 1'b1, 1, 0, 1'b0);
        gap(10);

        for (int i = 0; i < 4; i++) begin
            tick();
            rx = 1'b0;
        end
        gap(20);
        chk("glitch_valid", 32'(valid), 32'(0));
        chk("glitch_frame_err", 32'(act_fe), 32'(0));
        send_frame(8'h5A, 1'b1, 1, 0, 1'b0);
        gap(10);

        send_frame(8'h3C, 1'b0, 1, 40, 1'b0);
        gap(10);
        send_frame(8'h55, 1'b1, 1, 0, 1'b0);
        gap(10);

        send_frame(8'h11, 1'b1, 0, 0, 1'b0);
        gap(5);
        send_frame(8'h22, 1'b1, 0, 0, 1'b0);
        drain(5);

        send_frame(8'h11, 1'b1, 0, 0, 1'b0);
        gap(5);
        send_frame(8'h22, 1'b1, 2, 0, 1'b0);
        chk("b2b_msg", 32'(message), 32'(8'h22));
        drain(5);

        reset_mid(8'hFF, 60);
        gap(5);
        send_frame(8'h0F, 1'b1, 1, 0, 1'b0);
        gap(10);

        if (PB != 0) begin
            send_frame(8'h07, 1'b1, 1, 0, 1'b0);
            gap(10);
            send_frame(8'h07, 1'b1, 1, 0, 1'b1);
            gap(10);
        end

        for (int f = 0; f < 40; f++) begin
            d   = N'($urandom);
            stp = ($urandom_range(0, 9) != 0);
            flp = (PB != 0) && ($urandom_range(0, 7) == 0);
            send_frame(d, stp, int'($urandom_range(0, 2)), int'($urandom_range(0, 30)), flp);
            gap(int'($urandom_range(3, 12)));
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    tick();
                    rx = 1'b0;
                end
                gap(20);
            end
        end

        drain(5);
        chk("queue_drained", 32'(exp_acc.size()), 32'(0));
        chk("frame_err_total", 32'(act_fe), 32'(exp_fe));
        chk("overrun_total", 32'(act_ovr), 32'(exp_ovr));
        chk("parity_err_total", 32'(act_pe), 32'(exp_pe));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
